// File: rtl/golomb_result_recorder_pkg.sv
// Shared definitions for the Golomb result recorder slice.
// Holds the default geometry (mark count, mark width, limit reset value),
// the counter width, the stream FSM state type and the index-width helper.
package golomb_result_recorder_pkg;

  localparam int NUMPOS_DEF     = 5;    // index of last mark
  localparam int VAL_W_DEF      = 8;    // width of one mark value
  localparam int LIMIT_INIT_DEF = 255;  // search bound after reset (exclusive)
  localparam int CNT_W          = 16;   // found/drop counter width

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Bits needed to address mark indices 0..numpos.
  function automatic int idx_w(input int numpos);
    return (numpos < 1) ? 1 : $clog2(numpos + 1);
  endfunction

endpackage

// File: rtl/golomb_result_recorder_if.sv
// Mark stream port: one beat per mark, valid/ready handshake.
//   out_valid  beat valid               (master -> slave)
//   out_ready  consumer accepts beat    (slave  -> master)
//   out_index  mark index of the beat   (master -> slave)
//   out_mark   mark value of the beat   (master -> slave)
//   out_last   beat carries index NUMPOS (master -> slave)
interface golomb_result_recorder_if
  import golomb_result_recorder_pkg::*;
#(
  parameter int NUMPOS = NUMPOS_DEF,
  parameter int VAL_W  = VAL_W_DEF
) ();

  localparam int IDX_W = idx_w(NUMPOS);

  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_index;
  logic [VAL_W-1:0] out_mark;
  logic             out_last;

  modport master (
    output out_valid, out_index, out_mark, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_index, out_mark, out_last,
    output out_ready
  );

endinterface

// File: rtl/golomb_result_recorder_ruler_buf.sv
// golomb_ruler_buf: one ruler of NUMPOS+1 marks held in registers.
//   clock, reset  clock / synchronous active-high clear
//   load          capture din (all marks) at the clock edge
//   din           flat ruler, mark k at [k*VAL_W +: VAL_W]
//   rd_idx        mark index to read
//   rd_val        mark at rd_idx (combinational)
//   q             whole ruler, same flat layout as din
module golomb_ruler_buf
  import golomb_result_recorder_pkg::*;
#(
  parameter int NUMPOS = NUMPOS_DEF,
  parameter int VAL_W  = VAL_W_DEF,
  parameter int IDX_W  = idx_w(NUMPOS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic [(NUMPOS+1)*VAL_W-1:0] din,
  input  logic [IDX_W-1:0]            rd_idx,
  output logic [VAL_W-1:0]            rd_val,
  output logic [(NUMPOS+1)*VAL_W-1:0] q
);

  logic [NUMPOS:0][VAL_W-1:0] mem;

  always_ff @(posedge clock) begin
    if (reset)     mem <= '0;
    else if (load) mem <= din;
  end

  assign rd_val = mem[rd_idx];
  assign q      = mem;

endmodule

// File: rtl/golomb_result_recorder.sv
// golomb_result_recorder: captures each ruler the leaf counter reports,
// tightens the shared search limit to its length and streams its marks out.
// One ruler streams while at most one waits; a newer find replaces a waiting one.
//   clock, reset        clock / synchronous active-high reset
//   leaf_ready          leaf counter result-ready flag
//   leaf_succ           leaf counter success flag
//   leaf_val            leaf (last) mark position
//   marks_in            flat marks, mark k at [k*VAL_W +: VAL_W]
//   limit               exclusive upper bound fed to every mark counter
//   limit_upd           one-cycle pulse in the cycle limit takes its new value
//   out (master)        mark stream: out_valid/out_ready/out_index/out_mark/out_last
//   found_cnt           accepted rulers, saturating
//   drop_cnt            waiting rulers overwritten before streaming, saturating
module golomb_result_recorder
  import golomb_result_recorder_pkg::*;
#(
  parameter int NUMPOS     = NUMPOS_DEF,
  parameter int VAL_W      = VAL_W_DEF,
  parameter int LIMIT_INIT = LIMIT_INIT_DEF
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        leaf_ready,
  input  logic                        leaf_succ,
  input  logic [VAL_W-1:0]            leaf_val,
  input  logic [(NUMPOS+1)*VAL_W-1:0] marks_in,
  output logic [VAL_W-1:0]            limit,
  output logic                        limit_upd,
  golomb_result_recorder_if.master    out,
  output logic [CNT_W-1:0]            found_cnt,
  output logic [CNT_W-1:0]            drop_cnt
);

  localparam int               IDX_W     = idx_w(NUMPOS);
  localparam int               RULER_W   = (NUMPOS+1)*VAL_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUMPOS);
  localparam logic [VAL_W-1:0] LIMIT_RST = VAL_W'(LIMIT_INIT);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx_q, idx_n;
  logic               valid_q, valid_n;
  logic               pend_valid, pend_valid_n;
  logic               leaf_ready_q;

  logic               cap, accept, hs, last_hs;
  logic               stream_ld, stream_from_pend, pend_ld, drop_inc;
  logic [RULER_W-1:0] new_ruler, stream_din, pend_q, stream_q;
  logic [VAL_W-1:0]   stream_mark, pend_mark;
  logic               unused_bits;

  // leaf_succ stays high until the leaf is re-enabled, so only the rising
  // edge of leaf_ready counts. leaf_ready_q resets high so a leaf that is
  // already ready out of reset does not produce a spurious capture.
  assign cap     = leaf_succ & leaf_ready & ~leaf_ready_q;
  assign accept  = cap & (leaf_val < limit);
  assign hs      = valid_q & out.out_ready;
  assign last_hs = hs & (idx_q == LAST_IDX);

  // The leaf reports its own position separately; the top slot of marks_in
  // is not trusted.
  always_comb begin
    new_ruler = marks_in;
    new_ruler[NUMPOS*VAL_W +: VAL_W] = leaf_val;
  end

  assign stream_din = stream_from_pend ? pend_q : new_ruler;

  golomb_ruler_buf #(.NUMPOS(NUMPOS), .VAL_W(VAL_W), .IDX_W(IDX_W)) stream_buf (
    .clock  (clock),
    .reset  (reset),
    .load   (stream_ld),
    .din    (stream_din),
    .rd_idx (idx_q),
    .rd_val (stream_mark),
    .q      (stream_q)
  );

  golomb_ruler_buf #(.NUMPOS(NUMPOS), .VAL_W(VAL_W), .IDX_W(IDX_W)) pend_buf (
    .clock  (clock),
    .reset  (reset),
    .load   (pend_ld),
    .din    (new_ruler),
    .rd_idx ('0),
    .rd_val (pend_mark),
    .q      (pend_q)
  );

  assign unused_bits = ^{stream_q, pend_mark};

  // Stream FSM: next state and buffer control.
  always_comb begin
    state_n          = state;
    idx_n            = idx_q;
    valid_n          = valid_q;
    pend_valid_n     = pend_valid;
    stream_ld        = 1'b0;
    stream_from_pend = 1'b0;
    pend_ld          = 1'b0;
    drop_inc         = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          stream_ld = 1'b1;
          idx_n     = '0;
          valid_n   = 1'b1;
          state_n   = STREAM;
        end
      end
      STREAM: begin
        if (last_hs) begin
          idx_n = '0;
          if (accept) begin
            // Newest ruler goes straight out; a waiting one is now stale.
            stream_ld = 1'b1;
            if (pend_valid) begin
              pend_valid_n = 1'b0;
              drop_inc     = 1'b1;
            end
          end else if (pend_valid) begin
            stream_ld        = 1'b1;
            stream_from_pend = 1'b1;
            pend_valid_n     = 1'b0;
          end else begin
            valid_n = 1'b0;
            state_n = IDLE;
          end
        end else begin
          if (hs) idx_n = idx_q + IDX_W'(1);
          if (accept) begin
            pend_ld      = 1'b1;
            pend_valid_n = 1'b1;
            if (pend_valid) drop_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      idx_q        <= '0;
      valid_q      <= 1'b0;
      pend_valid   <= 1'b0;
      leaf_ready_q <= 1'b1;
      limit        <= LIMIT_RST;
      limit_upd    <= 1'b0;
      found_cnt    <= '0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_n;
      idx_q        <= idx_n;
      valid_q      <= valid_n;
      pend_valid   <= pend_valid_n;
      leaf_ready_q <= leaf_ready;
      limit_upd    <= accept;
      if (accept) limit <= leaf_val;
      if (accept && found_cnt != '1) found_cnt <= found_cnt + CNT_W'(1);
      if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign out.out_valid = valid_q;
  assign out.out_index = idx_q;
  assign out.out_mark  = stream_mark;
  assign out.out_last  = valid_q & (idx_q == LAST_IDX);

endmodule
